// File: rtl/bytebeat_pkg.sv
// rtl/bytebeat_pkg.sv - shared types and constants for the bytebeat sample channel
package bytebeat_pkg;

  localparam int SAMPLE_W = 8;
  localparam int PWM_W    = 8;

  typedef logic [SAMPLE_W-1:0] sample_t;
  typedef logic [PWM_W-1:0]    pwm_cnt_t;

  localparam sample_t SAMPLE_MIDSCALE = 8'h80;

  // What a sample boundary does with the playback register.
  typedef enum logic [1:0] {
    BND_NONE,
    BND_CONSUME,
    BND_BYPASS,
    BND_UNDERRUN
  } bnd_action_e;

  function automatic int per_cnt_width(input int periods);
    return (periods > 1) ? $clog2(periods) : 1;
  endfunction

endpackage

// File: rtl/bytebeat_pwm_core.sv
// rtl/bytebeat_pwm_core.sv - free-running 8-bit PWM counter with registered duty compare
module bytebeat_pwm_core
  import bytebeat_pkg::*;
(
  input  logic    clk,
  input  logic    reset,
  input  sample_t level,
  output logic    wrap,
  output logic    pwm_out
);

  pwm_cnt_t pwm_cnt_q, pwm_cnt_d;
  logic     pwm_out_q, pwm_out_d;

  always_comb begin
    pwm_cnt_d = pwm_cnt_q + pwm_cnt_t'(1);
    pwm_out_d = (pwm_cnt_q < level);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pwm_cnt_q <= '0;
      pwm_out_q <= 1'b0;
    end else begin
      pwm_cnt_q <= pwm_cnt_d;
      pwm_out_q <= pwm_out_d;
    end
  end

  // Last count of the PWM period; the counter reads 0 on the following cycle.
  assign wrap    = (pwm_cnt_q == '1);
  assign pwm_out = pwm_out_q;

endmodule

// File: rtl/bytebeat_pwm_sink.sv
// rtl/bytebeat_pwm_sink.sv - sample sink: one-entry holding buffer, per-sample period pacing, underrun tracking
module bytebeat_pwm_sink
  import bytebeat_pkg::*;
#(
  parameter int PERIODS_PER_SAMPLE = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] sample_in,
  input  logic       sample_in_vld,
  output logic       sample_in_rdy,
  output logic       pwm_out,
  output logic       underrun,
  output logic [7:0] underrun_count
);

  localparam int              PER_W    = per_cnt_width(PERIODS_PER_SAMPLE);
  localparam logic [PER_W-1:0] PER_LAST = PER_W'(PERIODS_PER_SAMPLE - 1);

  logic [PER_W-1:0] per_cnt_q, per_cnt_d;
  sample_t          cur_q, cur_d;
  sample_t          next_q, next_d;
  logic             next_valid_q, next_valid_d;
  logic             underrun_q, underrun_d;
  logic [7:0]       underrun_count_q, underrun_count_d;

  logic        wrap;
  logic        boundary;
  logic        xfer;
  bnd_action_e action;

  bytebeat_pwm_core u_core (
    .clk     (clk),
    .reset   (reset),
    .level   (cur_q),
    .wrap    (wrap),
    .pwm_out (pwm_out)
  );

  // Ready comes only from registered state so it never waits on vld.
  assign sample_in_rdy = ~next_valid_q & ~reset;
  assign xfer          = sample_in_vld & sample_in_rdy;
  assign boundary      = wrap & (per_cnt_q == PER_LAST);

  always_comb begin
    per_cnt_d = per_cnt_q;
    if (wrap) begin
      per_cnt_d = (per_cnt_q == PER_LAST) ? '0 : per_cnt_q + 1'b1;
    end

    action = BND_NONE;
    if (boundary) begin
      if (next_valid_q)  action = BND_CONSUME;
      else if (xfer)     action = BND_BYPASS;
      else               action = BND_UNDERRUN;
    end
  end

  always_comb begin
    cur_d            = cur_q;
    next_d           = next_q;
    next_valid_d     = next_valid_q;
    underrun_d       = 1'b0;
    underrun_count_d = underrun_count_q;

    case (action)
      BND_CONSUME: begin
        cur_d        = next_q;
        next_valid_d = 1'b0;
      end
      BND_BYPASS: begin
        cur_d = sample_in;
      end
      BND_UNDERRUN: begin
        underrun_d = 1'b1;
        if (underrun_count_q != 8'hFF) begin
          underrun_count_d = underrun_count_q + 8'd1;
        end
      end
      BND_NONE: begin
        if (xfer) begin
          next_d       = sample_in;
          next_valid_d = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      per_cnt_q        <= '0;
      cur_q            <= SAMPLE_MIDSCALE;
      next_q           <= '0;
      next_valid_q     <= 1'b0;
      underrun_q       <= 1'b0;
      underrun_count_q <= '0;
    end else begin
      per_cnt_q        <= per_cnt_d;
      cur_q            <= cur_d;
      next_q           <= next_d;
      next_valid_q     <= next_valid_d;
      underrun_q       <= underrun_d;
      underrun_count_q <= underrun_count_d;
    end
  end

  assign underrun       = underrun_q;
  assign underrun_count = underrun_count_q;

endmodule
